// File: rtl/logic_operand_stage.sv
// Operand FIFO feeding an external combinational logic unit, with a registered
// result stage under valid/ready handshake and a wrapping hand-off counter.
module logic_operand_stage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic [WIDTH-1:0]         lu_a,
    output logic [WIDTH-1:0]         lu_b,
    input  logic [WIDTH-1:0]         lu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              done_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t         mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          push, pop, can_load, res_fire;

    // No bypass: a full FIFO refuses input even when the head pops this cycle.
    assign in_ready = (count < FULL);
    assign push     = in_valid && in_ready;
    assign can_load = (count != '0) && (!res_valid || res_ready);
    assign pop      = can_load;
    assign res_fire = res_valid && res_ready;

    assign lu_a = (count != '0) ? mem[rptr].a : '0;
    assign lu_b = (count != '0) ? mem[rptr].b : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{a: in_a, b: in_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Reload takes priority over clearing, so back-to-back results keep valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b1;
            done_cnt  <= '0;
        end else begin
            if (can_load) begin
                res_valid <= 1'b1;
                res_data  <= lu_out;
                res_zero  <= (lu_out == '0);
            end else if (res_fire) begin
                res_valid <= 1'b0;
            end
            if (res_fire)
                done_cnt <= done_cnt + 16'd1;
        end
    end
endmodule
